// File: rtl/if_stage_if.sv
// Instruction-memory fetch port of if_stage: the fetch request going out and the
// fetched word coming back, bundled so the fetch stage and the SRAM model share one port.
interface if_stage_if;
    // Handshake: a request is live in every cycle where imem_re_o=1, for address imem_addr_o.
    // It completes in the cycle where imem_ready_i=1, and imem_rdata_i is valid in that cycle only.
    // If imem_addr_o changes, or imem_re_o drops, the old request is abandoned and never completes.
    logic        imem_re_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata_i;
    logic        imem_ready_i;

    modport master (
        output imem_re_o,
        output imem_addr_o,
        input  imem_rdata_i,
        input  imem_ready_i
    );

    modport slave (
        input  imem_re_o,
        input  imem_addr_o,
        output imem_rdata_i,
        output imem_ready_i
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem handshake, HOLD parking buffer and IF/ID register.
// Optional macro BRANCH_DELAY_SLOT_EN: the instruction after a taken branch executes instead of being squashed.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_i,
    input  logic        mem_stall_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    if_stage_if.master  imem,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o,
    output logic        valid_o,
    output logic [1:0]  dbg_state_o
);

    // dbg_state_o encoding: 0 = RST, 1 = FETCH, 2 = HOLD.
    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [15:0] hold_buf_q, hold_buf_d;

`ifdef BRANCH_DELAY_SLOT_EN
    logic        redirect_pend_q, redirect_pend_d;
    logic [15:0] redirect_addr_q, redirect_addr_d;
`endif

    logic        fetched;
    logic [15:0] word;
    logic        take;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        hold_buf_d = hold_buf_q;
`ifdef BRANCH_DELAY_SLOT_EN
        redirect_pend_d = redirect_pend_q;
        redirect_addr_d = redirect_addr_q;
`endif
        take = 1'b0;

        // In HOLD the parked word stands in for a word returned this cycle.
        fetched = (state_q == S_HOLD) ||
                  ((state_q == S_FETCH) && !mem_stall_i && imem.imem_ready_i);
        word    = (state_q == S_HOLD) ? hold_buf_q : imem.imem_rdata_i;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            default: begin
                if (stall_req_i) begin
                    if ((state_q == S_FETCH) && fetched) begin
                        hold_buf_d = imem.imem_rdata_i;
                        state_d    = S_HOLD;
                    end
                end else begin
                    state_d = S_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
                    if (redirect_pend_q) begin
                        take = fetched;
                        if (fetched) begin
                            fetch_pc_d      = redirect_addr_q;
                            redirect_pend_d = 1'b0;
                        end
                    end else if (branch_flag_i) begin
                        take = fetched;
                        if (fetched) begin
                            fetch_pc_d = branch_addr_i;
                        end else begin
                            redirect_pend_d = 1'b1;
                            redirect_addr_d = branch_addr_i;
                        end
                    end else begin
                        take = fetched;
                        if (fetched) begin
                            fetch_pc_d = fetch_pc_q + 16'd1;
                        end
                    end
`else
                    // Redirect squashes whatever returned this cycle; the address change cancels it.
                    if (branch_flag_i) begin
                        fetch_pc_d = branch_addr_i;
                    end else begin
                        take = fetched;
                        if (fetched) begin
                            fetch_pc_d = fetch_pc_q + 16'd1;
                        end
                    end
`endif
                    if (take) begin
                        pc_d    = fetch_pc_q + 16'd1;
                        inst_d  = word;
                        valid_d = 1'b1;
                    end else begin
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RST;
            fetch_pc_q <= RESET_PC;
            pc_q       <= 16'h0000;
            inst_q     <= NOP_INST;
            valid_q    <= 1'b0;
            hold_buf_q <= 16'h0000;
`ifdef BRANCH_DELAY_SLOT_EN
            redirect_pend_q <= 1'b0;
            redirect_addr_q <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            hold_buf_q <= hold_buf_d;
`ifdef BRANCH_DELAY_SLOT_EN
            redirect_pend_q <= redirect_pend_d;
            redirect_addr_q <= redirect_addr_d;
`endif
        end
    end

    assign imem.imem_re_o   = (state_q == S_FETCH) && !mem_stall_i;
    assign imem.imem_addr_o = fetch_pc_q;
    assign pc_o             = pc_q;
    assign inst_o           = inst_q;
    assign valid_o          = valid_q;
    assign dbg_state_o      = state_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit pipeline: PC register, instruction-memory read handshake, and the IF/ID pipeline register in one block.
- Sits directly upstream of the decode stage. Drives its pc_i/inst_i and consumes its stall_req, branch_flag_o and branch_addr_o.
- Word-addressed; one instruction per 16-bit word.

Parameters:
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP_INST, 16'h0800, bubble instruction loaded into IF/ID on flush/bubble.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall_req_i  input  1  decode-stage stall; IF/ID and PC hold.
- mem_stall_i  input  1  memory stage owns the shared SRAM this cycle; no fetch may be issued.
- branch_flag_i  input  1  decode resolved a taken branch/jump.
- branch_addr_i  input  16  branch target.
- imem_re_o  output  1  fetch request.
- imem_addr_o  output  16  fetch address.
- imem_rdata_i  input  16  fetched word; valid when imem_ready_i=1.
- imem_ready_i  input  1  request completes this cycle (0..n wait cycles).
- pc_o  output  16  address+1 of inst_o (the next-sequential PC, used by decode for relative branches).
- inst_o  output  16  instruction to decode.
- valid_o  output  1  inst_o is a real instruction, not a bubble.

Behaviour:
- Reset (async): state=RST, fetch_pc=RESET_PC, pc_o=0, inst_o=NOP_INST, valid_o=0, imem_re_o=0, imem_addr_o=RESET_PC, redirect_pend=0, hold_buf cleared.
- States:
  - RST: one idle cycle after rst deasserts, then FETCH.
  - FETCH: imem_re_o=~mem_stall_i, imem_addr_o=fetch_pc.
  - HOLD: a fetched word is parked in hold_buf; imem_re_o=0.
- Priority each cycle: stall_req_i > branch_flag_i > mem_stall_i > normal advance.
- FETCH, imem_ready_i=1, no stall, no branch: IF/ID <= {fetch_pc+1, imem_rdata_i, valid=1}; fetch_pc <= fetch_pc+1. Throughput is 1 instruction/cycle with zero wait.
- FETCH, imem_ready_i=0: IF/ID loads a bubble (NOP_INST, valid=0, pc_o unchanged) unless stall_req_i.
- mem_stall_i=1 in FETCH: no request is issued, fetch_pc holds, imem_ready_i is ignored, IF/ID loads a bubble (unless stall_req_i).
- stall_req_i=1: IF/ID and fetch_pc hold. If imem_ready_i=1 in FETCH that cycle, the word goes to hold_buf and the state goes to HOLD. branch_flag_i is ignored, because decode re-presents it.
- HOLD, stall_req_i=0: IF/ID <= hold_buf, fetch_pc+1, state goes to FETCH. A branch in this cycle applies per the branch rules, with hold_buf acting as the "fetched" word.
- Branch (stall_req_i=0, branch_flag_i=1), without the delay-slot macro: fetch_pc <= branch_addr_i. Any word returned this cycle is discarded, IF/ID <= bubble, state goes to FETCH. Effective penalty is 1 bubble.
- An outstanding request abandoned on redirect is not re-issued. The address change itself is the cancel; the memory must accept an address change.
- PC increment wraps 16'hFFFF -> 16'h0000 with no flag.
- rst asserted mid-wait or in HOLD: all state and buffered data are discarded immediately.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: the instruction after a branch (the delay slot) always executes.
  - If the delay-slot word returns in the branch cycle, it loads into IF/ID normally (valid=1) and fetch_pc <= branch_addr_i.
  - If it has not yet returned: redirect_pend=1 and redirect_addr=branch_addr_i. The slot fetch completes and loads into IF/ID; on that load, fetch_pc <= redirect_addr and redirect_pend clears.
  - A second branch_flag_i while redirect_pend=1 is ignored.
- Undefined: squash behaviour as stated above; redirect_pend logic is absent.

Test Plan:
- Reset release, zero-wait memory returning word=addr+16'h6900: inst_o sequence 6900,6901,6902; pc_o 1,2,3; valid_o=1 from the 2nd cycle after rst falls.
- imem_ready_i low 2 cycles at fetch_pc=5: 2 bubbles (inst_o=0800, valid_o=0), then inst_o=word@5, pc_o=6.
- stall_req_i high 3 cycles while word@7 returns: inst_o holds the prior word, state=HOLD, imem_re_o=0; after release inst_o=word@7, pc_o=8, no refetch of 7.
- branch_flag_i=1, branch_addr_i=16'h0040, while word@A is returning, macro off: next inst_o=0800 valid_o=0, then word@40, pc_o=41.
- Same branch with BRANCH_DELAY_SLOT_EN and 2-cycle wait on the slot word: slot word appears with valid_o=1, next fetch address 16'h0040. A repeat branch_flag_i during the wait is ignored.
- fetch_pc=16'hFFFF, mem_stall_i pulsed 1 cycle, and rst asserted mid-wait: no request while mem_stall_i=1. pc_o wraps to 0000 after word@FFFF. Async reset forces inst_o=0800, valid_o=0 within the same cycle.
